muldiv: RTL and testbench

Iterative RV32M multiply/divide unit in the execute stage. It takes the same forwarded `a`/`b` operand buses that feed `alu` and runs one 32-cycle shift-add or restoring-divide sequence per request. Its result joins the ALU result in the writeback select path. The pipeline stalls on `busy`.

---
 rtl/muldiv.sv | 94 +++++++++
 tb/tb_muldiv.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/muldiv.sv
// muldiv: iterative RV32M multiply/divide unit, fixed 32-cycle latency
module muldiv (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] res
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t      state;
    logic [2:0]  op_r;
    logic        sa, sb, bz;
    logic [31:0] md, hi, lo;
    logic [4:0]  cnt;
    logic        sa_in, sb_in, neg;
    logic [31:0] abs_a, abs_b, nh, nl, mh_neg, result;
    logic [32:0] sum, diff;
    // operand sign capture and one shift-add / restoring-divide step
    always_comb begin
        sa_in  = a[31] & (op[2] ? ~op[0] : (op[1] ^ op[0]));
        sb_in  = b[31] & (op[2] ? ~op[0] : (op[1:0] == 2'b01));
        abs_a  = sa_in ? -a : a;
        abs_b  = sb_in ? -b : b;
        sum    = {1'b0, hi} + (lo[0] ? {1'b0, md} : 33'd0);
        diff   = {hi, lo[31]} - {1'b0, md};
        nh     = op_r[2] ? (diff[32] ? {hi[30:0], lo[31]} : diff[31:0]) : sum[32:1];
        nl     = op_r[2] ? {lo[30:0], ~diff[32]} : {sum[0], lo[31:1]};
        neg    = sa ^ sb;
        mh_neg = ~nh + {31'd0, nl == 32'd0};
        case (op_r)
            3'b000:  result = nl;
            3'b001,
            3'b010:  result = neg ? mh_neg : nh;
            3'b011:  result = nh;
            3'b100:  result = bz ? 32'hFFFF_FFFF : (neg ? -nl : nl);
            3'b101:  result = nl;
            3'b110:  result = sa ? -nh : nh;
            default: result = nh;
        endcase
    end
    // control FSM with registered busy/done; multiplier/dividend sits in lo
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            res   <= 32'd0;
            cnt   <= 5'd0;
            op_r  <= 3'd0;
            sa    <= 1'b0;
            sb    <= 1'b0;
            bz    <= 1'b0;
            md    <= 32'd0;
            hi    <= 32'd0;
            lo    <= 32'd0;
        end else if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else if (state == CALC) begin
            hi <= nh;
            lo <= nl;
            if (cnt == 5'd0) begin
                res   <= result;
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
            end else begin
                cnt <= cnt - 5'd1;
            end
        end else begin
            done <= 1'b0;
            if (start) begin
                op_r  <= op;
                sa    <= sa_in;
                sb    <= sb_in;
                bz    <= (b == 32'd0);
                md    <= op[2] ? abs_b : abs_a;
                lo    <= op[2] ? abs_a : abs_b;
                hi    <= 32'd0;
                cnt   <= 5'd31;
                state <= CALC;
                busy  <= 1'b1;
            end else begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_muldiv.sv
// tb_muldiv: directed self-checking bench for muldiv
module tb_muldiv;
    logic        clk = 0, rst = 1, start = 0, flush = 0;
    logic [2:0]  op = 0;
    logic [31:0] a = 0, b = 0;
    logic        busy, done;
    logic [31:0] res;
    int          checks = 0, errors = 0;

    muldiv dut (.clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
                .flush(flush), .busy(busy), .done(done), .res(res));

    always #5 clk = ~clk;

    // issue one request and wait for done; returns result, latency, busy-cycle count
    task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] r, output int lat, output int bc);
        op = o; a = x; b = y; start = 1;
        @(posedge clk); #1;
        start = 0; a = $urandom; b = $urandom; op = 3'($urandom);
        bc = int'(busy); lat = 0;
        while (lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (done) break;
            bc += int'(busy);
        end
        r = res;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        checks++; if (res !== 32'd0) begin errors++; $display("FAIL reset_res got %h exp 0", res); end
        @(posedge clk); #1; rst = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_mul();
        logic [31:0] r; int lat, bc;
        do_op(3'b000, 32'd7, 32'd6, r, lat, bc);
        checks++; if (r !== 32'h2A) begin errors++; $display("FAIL mul_res got %h exp 0000002a", r); end
        checks++; if (lat !== 32) begin errors++; $display("FAIL mul_latency got %0d exp 32", lat); end
        checks++; if (bc !== 32) begin errors++; $display("FAIL mul_busy_cycles got %0d exp 32", bc); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mul_busy_with_done got %b exp 0", busy); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL mul_done_width got %b exp 0", done); end
    endtask

    task automatic test_high();
        logic [2:0]  o [4] = '{3'b001, 3'b011, 3'b010, 3'b001};
        logic [31:0] x [4] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] y [4] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
        logic [31:0] e [4] = '{32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] r; int lat, bc;
        for (int i = 0; i < 4; i++) begin
            do_op(o[i], x[i], y[i], r, lat, bc);
            checks++; if (r !== e[i]) begin errors++; $display("FAIL high_%0d got %h exp %h", i, r, e[i]); end
            checks++; if (lat !== 32) begin errors++; $display("FAIL high_lat_%0d got %0d exp 32", i, lat); end
        end
    endtask

    task automatic test_div();
        logic [2:0]  o [8] = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b100, 3'b111, 3'b100, 3'b110};
        logic [31:0] x [8] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'd100,
                               32'd5, 32'd5, 32'h80000000, 32'h80000000};
        logic [31:0] y [8] = '{32'd2, 32'd2, 32'd2, 32'd7, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] e [8] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'd2,
                               32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};
        logic [31:0] r; int lat, bc;
        for (int i = 0; i < 8; i++) begin
            do_op(o[i], x[i], y[i], r, lat, bc);
            checks++; if (r !== e[i]) begin errors++; $display("FAIL div_%0d got %h exp %h", i, r, e[i]); end
            checks++; if (lat !== 32) begin errors++; $display("FAIL div_lat_%0d got %0d exp 32", i, lat); end
        end
    endtask

    task automatic test_ignore_start();
        int lat = 0;
        op = 3'b000; a = 32'd3; b = 32'd4; start = 1;
        @(posedge clk); #1; start = 0;
        repeat (9) @(posedge clk);
        #1; op = 3'b000; a = 32'd100; b = 32'd100; start = 1;
        @(posedge clk); #1; start = 0; lat = 10;
        while (lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (done) break;
        end
        checks++; if (res !== 32'd12) begin errors++; $display("FAIL ignore_start_res got %h exp 0000000c", res); end
        checks++; if (lat !== 32) begin errors++; $display("FAIL ignore_start_lat got %0d exp 32", lat); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r; int lat, bc, drop = 0;
        do_op(3'b000, 32'd3, 32'd4, r, lat, bc);
        checks++; if (r !== 32'd12) begin errors++; $display("FAIL b2b_first got %h exp 0000000c", r); end
        op = 3'b101; a = 32'd9; b = 32'd3; start = 1;
        @(posedge clk); #1; start = 0;
        lat = 0;
        while (lat < 100) begin
            if (busy !== 1'b1) drop++;
            @(posedge clk); #1;
            lat++;
            if (done) break;
        end
        checks++; if (drop !== 0) begin errors++; $display("FAIL b2b_busy_drop got %0d exp 0", drop); end
        checks++; if (lat !== 32) begin errors++; $display("FAIL b2b_lat got %0d exp 32", lat); end
        checks++; if (res !== 32'd3) begin errors++; $display("FAIL b2b_res got %h exp 00000003", res); end
    endtask

    task automatic test_flush();
        int seen = 0;
        op = 3'b000; a = 32'd5; b = 32'd5; start = 1;
        @(posedge clk); #1; start = 0;
        repeat (9) @(posedge clk);
        #1; flush = 1;
        @(posedge clk); #1; flush = 0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b exp 0", busy); end
        repeat (40) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL flush_done got %0d exp 0", seen); end
        checks++; if (res !== 32'd3) begin errors++; $display("FAIL flush_res got %h exp 00000003", res); end
    endtask

    task automatic test_rst();
        logic [31:0] r; int lat, bc;
        op = 3'b000; a = 32'd9; b = 32'd9; start = 1;
        @(posedge clk); #1; start = 0;
        repeat (5) @(posedge clk);
        #2; rst = 1; #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
        checks++; if (res !== 32'd0) begin errors++; $display("FAIL rst_res got %h exp 0", res); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", done); end
        #1; rst = 0;
        @(posedge clk); #1;
        do_op(3'b000, 32'd2, 32'd2, r, lat, bc);
        checks++; if (r !== 32'd4) begin errors++; $display("FAIL rst_mul got %h exp 00000004", r); end
        checks++; if (lat !== 32) begin errors++; $display("FAIL rst_lat got %0d exp 32", lat); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_high();
        test_div();
        test_ignore_start();
        test_back_to_back();
        test_flush();
        test_rst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
